// File: rtl/fxp_mult_pipe.sv
// Pipelined sign-magnitude fixed-point multiplier with valid/ready handshake.
// The product is formed ahead of slot 0; the remaining slots form a collapsing skid pipeline.
module fxp_mult_pipe #(
    parameter int WIDTH  = 16,
    parameter int FRAC   = 8,
    parameter int STAGES = 2,
    parameter int ROUND  = 1,
    parameter int SAT    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_p,
    output logic             out_ovf
);

    localparam int MW  = WIDTH - 1;
    localparam int PW  = 2 * MW;
    localparam int RSH = (FRAC > 0) ? FRAC - 1 : 0;
    localparam logic [PW:0] ONE     = {{PW{1'b0}}, 1'b1};
    localparam logic [PW:0] RND_ADD = (ROUND != 0 && FRAC > 0) ? (ONE << RSH) : '0;

    logic [PW-1:0]    prod;
    logic [PW:0]      rounded;
    logic [PW:0]      m_wide;
    logic             ovf_new;
    logic [MW-1:0]    mag;
    logic [WIDTH-1:0] p_new;

    always_comb begin
        prod    = {{MW{1'b0}}, in_a[MW-1:0]} * {{MW{1'b0}}, in_b[MW-1:0]};
        rounded = {1'b0, prod} + RND_ADD;
        m_wide  = rounded >> FRAC;
        ovf_new = |m_wide[PW:MW];
        mag     = m_wide[MW-1:0];
        if (ovf_new && SAT != 0) begin
            mag = '1;
        end
        // a zero magnitude always leaves with a positive sign
        p_new   = {(in_a[MW] ^ in_b[MW]) & (|mag), mag};
    end

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] ovf_q;
    logic [WIDTH-1:0]  p_q [STAGES];
    logic [STAGES-1:0] free;

    // A slot may load when it is empty or its contents move on this cycle.
    always_comb begin
        logic carry;
        carry = out_ready;
        free  = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            free[i] = !valid_q[i] | carry;
            carry   = free[i];
        end
    end

    assign in_ready = rst_n & free[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            ovf_q   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                p_q[i] <= '0;
            end
        end else begin
            if (free[0]) begin
                valid_q[0] <= in_valid;
                p_q[0]     <= p_new;
                ovf_q[0]   <= ovf_new;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (free[i]) begin
                    valid_q[i] <= valid_q[i-1];
                    p_q[i]     <= p_q[i-1];
                    ovf_q[i]   <= ovf_q[i-1];
                end
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_p     = p_q[STAGES-1];
    assign out_ovf   = ovf_q[STAGES-1];

endmodule

// File: tb/tb_fxp_mult_pipe.sv
// Bench for fxp_mult_pipe: sixteen instances cover every STAGES/ROUND/SAT combination
// at WIDTH=16 FRAC=8; instance g has STAGES=g/4+1, ROUND=(g/2)%2, SAT=g%2.
module tb_fxp_mult_pipe;

    localparam int NCFG = 16;
    localparam int GDEF = 7;   // STAGES=2 ROUND=1 SAT=1
    localparam int GTRN = 5;   // STAGES=2 ROUND=0 SAT=1
    localparam int GWRP = 6;   // STAGES=2 ROUND=1 SAT=0

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv [NCFG];
    logic        ir [NCFG];
    logic        ov [NCFG];
    logic        ordy [NCFG];
    logic        oo [NCFG];
    logic [15:0] ia [NCFG];
    logic [15:0] ib [NCFG];
    logic [15:0] op [NCFG];

    int tests = 0;
    int fails = 0;

    logic [16:0] expq [NCFG][$];
    int          got_lat [NCFG];
    logic [15:0] got_p [NCFG];
    logic        got_o [NCFG];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        fxp_mult_pipe #(
            .WIDTH(16), .FRAC(8), .STAGES(g/4 + 1), .ROUND((g/2) % 2), .SAT(g % 2)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(iv[g]), .in_ready(ir[g]), .in_a(ia[g]), .in_b(ib[g]),
            .out_valid(ov[g]), .out_ready(ordy[g]), .out_p(op[g]), .out_ovf(oo[g])
        );
    end

    function automatic int stg(input int g);
        return g/4 + 1;
    endfunction

    // Reference: integer product of magnitudes, divide by 2^FRAC, then clamp or wrap.
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b, input int g);
        longint unsigned pr;
        longint unsigned m;
        logic [15:0]     mag;
        logic            ovf;
        pr  = 64'(a[14:0]);
        pr  = pr * 64'(b[14:0]);
        m   = (pr + (((g/2) % 2 == 1) ? 64'd128 : 64'd0)) / 64'd256;
        ovf = (m > 64'd32767);
        if (!ovf)          mag = 16'(m);
        else if (g % 2 == 1) mag = 16'h7FFF;
        else               mag = 16'(m % 64'd32768);
        if (mag != 16'd0 && (a[15] ^ b[15])) mag[15] = 1'b1;
        return {ovf, mag};
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] v;
        int          r;
        r = int'($urandom_range(0, 15));
        v = 16'($urandom);
        if (r == 0) begin
            case ($urandom_range(0, 3))
                0:       v = 16'h0000;
                1:       v = 16'h8000;
                2:       v = 16'h7FFF;
                default: v = 16'hFFFF;
            endcase
        end else if (r < 7) begin
            v[14:10] = 5'd0;
        end
        return v;
    endfunction

    task automatic drive_idle();
        for (int g = 0; g < NCFG; g++) begin
            iv[g] = 1'b0; ordy[g] = 1'b1; ia[g] = 16'h0; ib[g] = 16'h0;
        end
    endtask

    // One beat into every instance; records when and what each one emits.
    task automatic single(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        for (int g = 0; g < NCFG; g++) begin
            iv[g] = 1'b1; ia[g] = a; ib[g] = b; ordy[g] = 1'b1;
            got_lat[g] = 0; got_p[g] = 16'h0; got_o[g] = 1'b0;
        end
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            for (int g = 0; g < NCFG; g++) iv[g] = 1'b0;
            #1;
            for (int g = 0; g < NCFG; g++) begin
                if (ov[g] && got_lat[g] == 0) begin
                    got_lat[g] = k; got_p[g] = op[g]; got_o[g] = oo[g];
                end
            end
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        for (int g = 0; g < NCFG; g++) begin
            tests++;
            if (ov[g] !== 1'b0 || ir[g] !== 1'b0 || op[g] !== 16'h0 || oo[g] !== 1'b0) begin
                fails++;
                $display("FAIL reset_state cfg=%0d got v=%b r=%b p=%h o=%b want all zero",
                         g, ov[g], ir[g], op[g], oo[g]);
            end
        end
        rst_n = 1'b1;
        #1;
        for (int g = 0; g < NCFG; g++) begin
            tests++;
            if (ir[g] !== 1'b1) begin
                fails++;
                $display("FAIL reset_release_ready cfg=%0d got %b want 1", g, ir[g]);
            end
        end
    endtask

    task automatic test_basic();
        single(16'h0180, 16'h0200);
        for (int g = 0; g < NCFG; g++) begin
            tests++;
            if (got_lat[g] != stg(g)) begin
                fails++;
                $display("FAIL basic_latency cfg=%0d got %0d want %0d", g, got_lat[g], stg(g));
            end
            tests++;
            if (got_p[g] !== 16'h0300 || got_o[g] !== 1'b0) begin
                fails++;
                $display("FAIL basic_product cfg=%0d got %h/%b want 0300/0", g, got_p[g], got_o[g]);
            end
        end
    endtask

    task automatic test_sign();
        logic [15:0] av [4];
        logic [15:0] bv [4];
        logic [15:0] ev [4];
        av = '{16'h8180, 16'h8180, 16'h8000, 16'h8001};
        bv = '{16'h0200, 16'h8200, 16'h0100, 16'h0001};
        ev = '{16'h8300, 16'h0300, 16'h0000, 16'h0000};
        for (int v = 0; v < 4; v++) begin
            single(av[v], bv[v]);
            tests++;
            if (got_p[GDEF] !== ev[v]) begin
                fails++;
                $display("FAIL sign_vector%0d got %h want %h", v, got_p[GDEF], ev[v]);
            end
            for (int g = 0; g < NCFG; g++) begin
                tests++;
                if ({got_o[g], got_p[g]} !== model(av[v], bv[v], g) || got_lat[g] != stg(g)) begin
                    fails++;
                    $display("FAIL sign_model cfg=%0d vec=%0d got %h lat %0d want %h lat %0d",
                             g, v, {got_o[g], got_p[g]}, got_lat[g], model(av[v], bv[v], g), stg(g));
                end
            end
        end
    endtask

    task automatic test_round_sat();
        single(16'h0001, 16'h0080);
        tests++;
        if (got_p[GDEF] !== 16'h0001) begin
            fails++;
            $display("FAIL round_half_up got %h want 0001", got_p[GDEF]);
        end
        tests++;
        if (got_p[GTRN] !== 16'h0000) begin
            fails++;
            $display("FAIL round_truncate got %h want 0000", got_p[GTRN]);
        end
        single(16'h7FFF, 16'h8200);
        tests++;
        if (got_p[GDEF] !== 16'hFFFF || got_o[GDEF] !== 1'b1) begin
            fails++;
            $display("FAIL sat_clamp got %h/%b want FFFF/1", got_p[GDEF], got_o[GDEF]);
        end
        tests++;
        if (got_p[GWRP] !== 16'hFFFE || got_o[GWRP] !== 1'b1) begin
            fails++;
            $display("FAIL sat_wrap got %h/%b want FFFE/1", got_p[GWRP], got_o[GWRP]);
        end
        for (int g = 0; g < NCFG; g++) begin
            tests++;
            if ({got_o[g], got_p[g]} !== model(16'h7FFF, 16'h8200, g)) begin
                fails++;
                $display("FAIL ovf_model cfg=%0d got %h want %h", g, {got_o[g], got_p[g]},
                         model(16'h7FFF, 16'h8200, g));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] av [8];
        logic [15:0] bv [8];
        logic [16:0] q [$];
        logic [16:0] e;
        logic        exp_rdy;
        logic        pv = 1'b0;
        logic        pr = 1'b1;
        logic        saw_low = 1'b0;
        logic [15:0] pp = 16'h0;
        int          sent = 0;
        int          got = 0;
        for (int i = 0; i < 8; i++) begin
            av[i] = rand_op(); bv[i] = rand_op();
        end
        drive_idle();
        for (int c = 0; c < 60 && got < 8; c++) begin
            @(negedge clk);
            ordy[GDEF] = !(c >= 3 && c <= 7);
            iv[GDEF]   = (sent < 8);
            if (sent < 8) begin
                ia[GDEF] = av[sent]; ib[GDEF] = bv[sent];
            end
            #1;
            exp_rdy = !(q.size() == 2 && !ordy[GDEF]);
            if (!ir[GDEF]) saw_low = 1'b1;
            tests++;
            if (ir[GDEF] !== exp_rdy) begin
                fails++;
                $display("FAIL bp_in_ready cycle=%0d got %b want %b", c, ir[GDEF], exp_rdy);
            end
            if (pv && !pr) begin
                tests++;
                if (ov[GDEF] !== 1'b1 || op[GDEF] !== pp) begin
                    fails++;
                    $display("FAIL bp_stall_hold cycle=%0d got %b/%h want 1/%h", c, ov[GDEF], op[GDEF], pp);
                end
            end
            if (ov[GDEF] && ordy[GDEF]) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL bp_spurious cycle=%0d got %h want nothing", c, op[GDEF]);
                end else begin
                    e = q.pop_front();
                    got++;
                    if ({oo[GDEF], op[GDEF]} !== e) begin
                        fails++;
                        $display("FAIL bp_order cycle=%0d got %h want %h", c, {oo[GDEF], op[GDEF]}, e);
                    end
                end
            end
            if (iv[GDEF] && ir[GDEF]) begin
                q.push_back(model(av[sent], bv[sent], GDEF));
                sent++;
            end
            pv = ov[GDEF]; pr = ordy[GDEF]; pp = op[GDEF];
        end
        tests++;
        if (got != 8 || sent != 8) begin
            fails++;
            $display("FAIL bp_count got %0d out %0d in want 8 8", got, sent);
        end
        tests++;
        if (!saw_low) begin
            fails++;
            $display("FAIL bp_ready_drop got never-low want low while full");
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        for (int g = 0; g < NCFG; g++) begin
            iv[g] = 1'b1; ordy[g] = 1'b0; ia[g] = rand_op(); ib[g] = rand_op();
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (ov[GDEF] !== 1'b1) begin
            fails++;
            $display("FAIL mid_inflight got %b want 1", ov[GDEF]);
        end
        rst_n = 1'b0;
        for (int g = 0; g < NCFG; g++) iv[g] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        for (int g = 0; g < NCFG; g++) begin
            tests++;
            if (ov[g] !== 1'b0 || op[g] !== 16'h0 || oo[g] !== 1'b0) begin
                fails++;
                $display("FAIL mid_flush cfg=%0d got %b/%h/%b want 0/0000/0", g, ov[g], op[g], oo[g]);
            end
        end
        rst_n = 1'b1;
        drive_idle();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            for (int g = 0; g < NCFG; g++) begin
                tests++;
                if (ov[g] !== 1'b0) begin
                    fails++;
                    $display("FAIL mid_emerged cfg=%0d cycle=%0d got %h want none", g, c, op[g]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic        pv [NCFG];
        logic        pr [NCFG];
        logic [15:0] pp [NCFG];
        logic [16:0] e;
        logic        exp_rdy;
        for (int g = 0; g < NCFG; g++) begin
            expq[g].delete(); pv[g] = 1'b0; pr[g] = 1'b1; pp[g] = 16'h0;
        end
        for (int c = 0; c < 2512; c++) begin
            @(negedge clk);
            for (int g = 0; g < NCFG; g++) begin
                if (c < 2500) begin
                    iv[g]   = ($urandom_range(0, 9) < 7);
                    ordy[g] = ($urandom_range(0, 9) < 7);
                end else begin
                    iv[g] = 1'b0; ordy[g] = 1'b1;
                end
                ia[g] = rand_op(); ib[g] = rand_op();
            end
            #1;
            for (int g = 0; g < NCFG; g++) begin
                exp_rdy = !(expq[g].size() == stg(g) && !ordy[g]);
                tests++;
                if (ir[g] !== exp_rdy) begin
                    fails++;
                    $display("FAIL rand_ready cfg=%0d cycle=%0d got %b want %b", g, c, ir[g], exp_rdy);
                end
                if (pv[g] && !pr[g]) begin
                    tests++;
                    if (ov[g] !== 1'b1 || op[g] !== pp[g]) begin
                        fails++;
                        $display("FAIL rand_stall_hold cfg=%0d cycle=%0d got %b/%h want 1/%h",
                                 g, c, ov[g], op[g], pp[g]);
                    end
                end
                if (ov[g] && ordy[g]) begin
                    tests++;
                    if (expq[g].size() == 0) begin
                        fails++;
                        $display("FAIL rand_spurious cfg=%0d cycle=%0d got %h want nothing", g, c, op[g]);
                    end else begin
                        e = expq[g].pop_front();
                        if ({oo[g], op[g]} !== e) begin
                            fails++;
                            $display("FAIL rand_data cfg=%0d cycle=%0d got %h want %h",
                                     g, c, {oo[g], op[g]}, e);
                        end
                    end
                end
                if (iv[g] && ir[g]) expq[g].push_back(model(ia[g], ib[g], g));
                pv[g] = ov[g]; pr[g] = ordy[g]; pp[g] = op[g];
            end
        end
        for (int g = 0; g < NCFG; g++) begin
            tests++;
            if (expq[g].size() != 0) begin
                fails++;
                $display("FAIL rand_drain cfg=%0d got %0d left want 0", g, expq[g].size());
            end
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_basic();
        test_sign();
        test_round_sat();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
